// File: rtl/theremin_pkg.sv
// theremin_pkg
//   Shared types and helpers for the theremin period calibrator.
//   - cal_state_e : calibrator mode (RUN = producing deltas, CAL = learning refs)
//   - SAMPLE_DIV_DEFAULT : CLK cycles per audio sample tick (100 MHz / 48 kHz)
//   - sat_to_bits : clamp a signed value to the range of an out_bits-wide
//                   two's complement word
package theremin_pkg;

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_CAL = 1'b1
   } cal_state_e;

   localparam int unsigned SAMPLE_DIV_DEFAULT = 2083;

   // Works on a 64-bit signed carrier so one helper serves any DATA_BITS/OUT_BITS
   // combination below 64 bits; the caller keeps the low out_bits.
   function automatic logic signed [63:0] sat_to_bits(input logic signed [63:0] v,
                                                       input int unsigned       out_bits);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_bits - 1));
      if (v > hi)      sat_to_bits = hi;
      else if (v < lo) sat_to_bits = lo;
      else             sat_to_bits = v;
   endfunction

endpackage

// File: rtl/theremin_period_calibrator_if.sv
// theremin_period_calibrator_if
//   Delta output stream of the calibrator: a pitch/volume delta pair qualified
//   by OUT_VALID, accepted when OUT_VALID & OUT_READY.
//   - master : calibrator side (drives deltas and OUT_VALID)
//   - slave  : consumer side (drives OUT_READY)
interface theremin_period_calibrator_if #(
   parameter int unsigned OUT_BITS = 24
);
   logic [OUT_BITS-1:0] PITCH_DELTA;
   logic [OUT_BITS-1:0] VOLUME_DELTA;
   logic                OUT_VALID;
   logic                OUT_READY;

   modport master (output PITCH_DELTA, output VOLUME_DELTA, output OUT_VALID,
                   input  OUT_READY);
   modport slave  (input  PITCH_DELTA, input  VOLUME_DELTA, input  OUT_VALID,
                   output OUT_READY);
endinterface

// File: rtl/theremin_sat_delta.sv
// theremin_sat_delta
//   One channel of the delta stage: registers clamp(ref_i - smp_i) into an
//   OUT_BITS signed word when en is high, holds otherwise.
//   - CLK, RESETN : clock, async active-low reset
//   - en          : a fresh sample is present on smp_i
//   - ref_i       : channel reference period (unsigned)
//   - smp_i       : captured sample period (unsigned)
//   - delta_q     : registered saturated delta (signed)
module theremin_sat_delta
   import theremin_pkg::*;
#(
   parameter int unsigned DATA_BITS = 32,
   parameter int unsigned OUT_BITS  = 24
) (
   input  logic                 CLK,
   input  logic                 RESETN,
   input  logic                 en,
   input  logic [DATA_BITS-1:0] ref_i,
   input  logic [DATA_BITS-1:0] smp_i,
   output logic [OUT_BITS-1:0]  delta_q
);
   logic signed [DATA_BITS:0] diff;
   logic signed [63:0]        sat;
   logic [OUT_BITS-1:0]       delta_d;
   logic                      sat_unused;

   always_comb begin
      // Both operands zero-extended by one bit, so the difference never wraps.
      diff    = $signed({1'b0, ref_i}) - $signed({1'b0, smp_i});
      sat     = sat_to_bits(64'(diff), OUT_BITS);
      delta_d = en ? sat[OUT_BITS-1:0] : delta_q;
   end

   // Clamped value always fits in OUT_BITS; the upper carrier bits are sign copies.
   assign sat_unused = ^sat[63:OUT_BITS];

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) delta_q <= '0;
      else         delta_q <= delta_d;
   end
endmodule

// File: rtl/theremin_period_calibrator.sv
// theremin_period_calibrator
//   Decimates filtered pitch/volume periods to a fixed sample tick, learns a
//   per-channel reference by averaging 2^CAL_SHIFT samples on request, and
//   streams saturated (ref - sample) deltas.
//   - CLK, RESETN            : clock, async active-low reset
//   - PITCH/VOLUME_PERIOD_FILTERED : unsigned period words
//   - CAL_START / CAL_BUSY   : calibration request pulse / in-progress flag
//   - PITCH_REF, VOLUME_REF  : current reference periods
//   - OVERRUN                : sticky, a pair was dropped on a full output
//   - out_if (master)        : PITCH_DELTA, VOLUME_DELTA, OUT_VALID, OUT_READY
//   Pipeline: tick edge captures samples, next edge registers deltas,
//   next edge loads the output register.
module theremin_period_calibrator
   import theremin_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 32,
   parameter int unsigned OUT_BITS   = 24,
   parameter int unsigned CAL_SHIFT  = 4,
   parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEFAULT
) (
   input  logic                 CLK,
   input  logic                 RESETN,
   input  logic [DATA_BITS-1:0] PITCH_PERIOD_FILTERED,
   input  logic [DATA_BITS-1:0] VOLUME_PERIOD_FILTERED,
   input  logic                 CAL_START,
   output logic                 CAL_BUSY,
   output logic [DATA_BITS-1:0] PITCH_REF,
   output logic [DATA_BITS-1:0] VOLUME_REF,
   output logic                 OVERRUN,
   theremin_period_calibrator_if.master out_if
);
   localparam int unsigned NCH    = 2;  // channel 0 = pitch, 1 = volume
   localparam int unsigned CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned ACC_W  = DATA_BITS + CAL_SHIFT;
   localparam int unsigned NCAL_W = CAL_SHIFT + 1;

   cal_state_e                      state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            tick;
   // [0]: sample regs hold a fresh capture, [1]: delta regs hold a RUN result
   logic [1:0]                      vld_pipe_q, vld_pipe_d;
   logic [NCH-1:0][DATA_BITS-1:0]   smp_q, smp_d, ref_q, ref_d, period_in;
   logic [NCH-1:0][ACC_W-1:0]       acc_q, acc_d, acc_sum;
   logic [NCAL_W-1:0]               ncal_q, ncal_d;
   logic [NCH-1:0][OUT_BITS-1:0]    delta, out_q, out_d;
   logic                            out_valid_q, out_valid_d;
   logic                            overrun_q, overrun_d;

   assign period_in[0] = PITCH_PERIOD_FILTERED;
   assign period_in[1] = VOLUME_PERIOD_FILTERED;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      theremin_sat_delta #(.DATA_BITS(DATA_BITS), .OUT_BITS(OUT_BITS)) u_sat (
         .CLK     (CLK),
         .RESETN  (RESETN),
         .en      (vld_pipe_q[0]),
         .ref_i   (ref_q[c]),
         .smp_i   (smp_q[c]),
         .delta_q (delta[c])
      );
   end

   always_comb begin
      tick  = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      smp_d = tick ? period_in : smp_q;
      for (int c = 0; c < NCH; c++) acc_sum[c] = acc_q[c] + ACC_W'(smp_q[c]);

      state_d       = state_q;
      acc_d         = acc_q;
      ncal_d        = ncal_q;
      ref_d         = ref_q;
      out_d         = out_q;
      out_valid_d   = out_valid_q;
      overrun_d     = overrun_q;
      vld_pipe_d[0] = tick;
      // A sample consumed while entering CAL must not reach the output.
      vld_pipe_d[1] = vld_pipe_q[0] && (state_q == ST_RUN) && !CAL_START;

      if (CAL_START) begin
         // Restart wins over a completing accumulation; also flushes output.
         state_d     = ST_CAL;
         acc_d       = '0;
         ncal_d      = '0;
         overrun_d   = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         if (state_q == ST_CAL && vld_pipe_q[0]) begin
            if (ncal_q == NCAL_W'((1 << CAL_SHIFT) - 1)) begin
               for (int c = 0; c < NCH; c++) ref_d[c] = acc_sum[c][CAL_SHIFT +: DATA_BITS];
               state_d = ST_RUN;
            end else begin
               acc_d  = acc_sum;
               ncal_d = ncal_q + NCAL_W'(1);
            end
         end

         if (vld_pipe_q[1]) begin
            if (!out_valid_q || out_if.OUT_READY) begin
               out_d       = delta;
               out_valid_d = 1'b1;
            end else begin
               overrun_d   = 1'b1;
            end
         end else if (out_if.OUT_READY) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         vld_pipe_q  <= '0;
         smp_q       <= '0;
         ref_q       <= '0;
         acc_q       <= '0;
         ncal_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         vld_pipe_q  <= vld_pipe_d;
         smp_q       <= smp_d;
         ref_q       <= ref_d;
         acc_q       <= acc_d;
         ncal_q      <= ncal_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign CAL_BUSY            = (state_q == ST_CAL);
   assign PITCH_REF           = ref_q[0];
   assign VOLUME_REF          = ref_q[1];
   assign OVERRUN             = overrun_q;
   assign out_if.PITCH_DELTA  = out_q[0];
   assign out_if.VOLUME_DELTA = out_q[1];
   assign out_if.OUT_VALID    = out_valid_q;
endmodule

// File: tb/tb_theremin_period_calibrator.sv
// Scoreboard bench: stimulus pushes hand-computed delta pairs per RUN tick,
// a negedge monitor pops and compares on every accepted output.
module tb_theremin_period_calibrator;
   localparam int SD = 8;

   logic        CLK = 1'b0;
   logic        RESETN = 1'b0;
   logic [31:0] pin = '0, vin = '0;
   logic        cal_start = 1'b0;
   logic        cal_busy, overrun;
   logic [31:0] pitch_ref, volume_ref;

   int n_tests = 0;
   int n_fail  = 0;
   int tcnt;

   typedef struct packed {
      logic [23:0] p;
      logic [23:0] v;
   } pair_t;
   pair_t exp_q[$];

   always #5 CLK = ~CLK;

   theremin_period_calibrator_if #(.OUT_BITS(24)) u_if ();

   theremin_period_calibrator #(
      .DATA_BITS(32), .OUT_BITS(24), .CAL_SHIFT(2), .SAMPLE_DIV(SD)
   ) dut (
      .CLK                    (CLK),
      .RESETN                 (RESETN),
      .PITCH_PERIOD_FILTERED  (pin),
      .VOLUME_PERIOD_FILTERED (vin),
      .CAL_START              (cal_start),
      .CAL_BUSY               (cal_busy),
      .PITCH_REF              (pitch_ref),
      .VOLUME_REF             (volume_ref),
      .OVERRUN                (overrun),
      .out_if                 (u_if)
   );

   // Bench-side view of the free-running tick phase (the tick cycle is tcnt == SD-1).
   always @(posedge CLK or negedge RESETN)
      if (!RESETN) tcnt <= 0;
      else         tcnt <= (tcnt == SD - 1) ? 0 : tcnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      pair_t e;
      if (RESETN && u_if.OUT_VALID && u_if.OUT_READY) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %0h/%0h expected none",
                     u_if.PITCH_DELTA, u_if.VOLUME_DELTA);
         end else begin
            e = exp_q.pop_front();
            chk("pitch_delta",  64'(u_if.PITCH_DELTA),  64'(e.p));
            chk("volume_delta", 64'(u_if.VOLUME_DELTA), 64'(e.v));
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Hold inputs through the next tick capture; return one cycle after the tick.
   task automatic do_tick(input logic [31:0] p, input logic [31:0] v,
                          input bit push, input logic [23:0] ep, input logic [23:0] ev);
      pair_t e;
      pin = p;
      vin = v;
      while (tcnt != SD - 1) step();
      step();
      if (push) begin
         e.p = ep;
         e.v = ev;
         exp_q.push_back(e);
      end
   endtask

   task automatic cal_pulse();
      repeat (3) step();
      cal_start = 1'b1;
      step();
      cal_start = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},     64'(cal_busy),          64'(0));
      chk({tag, "_pref"},     64'(pitch_ref),         64'(0));
      chk({tag, "_vref"},     64'(volume_ref),        64'(0));
      chk({tag, "_pdelta"},   64'(u_if.PITCH_DELTA),  64'(0));
      chk({tag, "_vdelta"},   64'(u_if.VOLUME_DELTA), 64'(0));
      chk({tag, "_valid"},    64'(u_if.OUT_VALID),    64'(0));
      chk({tag, "_overrun"},  64'(overrun),           64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      u_if.OUT_READY = 1'b1;
      repeat (2) step();
      chk_reset_vals("rst");
      RESETN = 1'b1;

      // Calibration: 4 samples of constant periods.
      cal_pulse();
      chk("cal_busy_rise", 64'(cal_busy), 64'(1));
      for (int i = 0; i < 4; i++) begin
         do_tick(32'h0001_0000, 32'h0002_0000, 1'b0, '0, '0);
         chk("cal_busy_hold", 64'(cal_busy), 64'(1));
      end
      step();
      chk("cal_busy_fall", 64'(cal_busy),   64'(0));
      chk("pitch_ref1",    64'(pitch_ref),  64'(32'h0001_0000));
      chk("volume_ref1",   64'(volume_ref), 64'(32'h0002_0000));

      do_tick(32'h0001_0000, 32'h0002_0000, 1'b1, 24'h000000, 24'h000000);

      // Positive delta and output latency.
      do_tick(32'h0000_FF00, 32'h0002_0000, 1'b1, 24'h000100, 24'h000000);
      chk("lat_t1_valid", 64'(u_if.OUT_VALID), 64'(0));
      step();
      chk("lat_t2_valid", 64'(u_if.OUT_VALID), 64'(0));
      step();
      chk("lat_t3_valid", 64'(u_if.OUT_VALID), 64'(1));

      // Negative saturation.
      do_tick(32'h0100_0000, 32'h0002_0000, 1'b1, 24'h800000, 24'h000000);

      // Restart after two calibration samples; refs from the last four only.
      cal_pulse();
      do_tick(32'h0000_0100, 32'h0000_0200, 1'b0, '0, '0);
      do_tick(32'h0000_0100, 32'h0000_0200, 1'b0, '0, '0);
      cal_pulse();
      chk("restart_busy", 64'(cal_busy), 64'(1));
      do_tick(32'h0100_0000, 32'h0000_1000, 1'b0, '0, '0);
      do_tick(32'h0100_0000, 32'h0000_2000, 1'b0, '0, '0);
      do_tick(32'h0100_0000, 32'h0000_3000, 1'b0, '0, '0);
      chk("restart_busy3", 64'(cal_busy), 64'(1));
      do_tick(32'h0100_0000, 32'h0000_4001, 1'b0, '0, '0);
      step();
      chk("restart_busy_fall", 64'(cal_busy),   64'(0));
      chk("pitch_ref2",        64'(pitch_ref),  64'(32'h0100_0000));
      chk("volume_ref2",       64'(volume_ref), 64'(32'h0000_2800));

      // Positive saturation and negative in-range delta.
      do_tick(32'h0000_0000, 32'h0000_3000, 1'b1, 24'h7FFFFF, 24'hFFF800);

      // Backpressure: first pair held, second dropped.
      repeat (3) step();
      u_if.OUT_READY = 1'b0;
      do_tick(32'h00FF_FF00, 32'h0000_2800, 1'b1, 24'h000100, 24'h000000);
      do_tick(32'h0100_0100, 32'h0000_2801, 1'b0, '0, '0);
      repeat (2) step();
      chk("bp_overrun",    64'(overrun),          64'(1));
      chk("bp_valid_held", 64'(u_if.OUT_VALID),   64'(1));
      chk("bp_pitch_held", 64'(u_if.PITCH_DELTA), 64'(24'h000100));
      u_if.OUT_READY = 1'b1;
      step();
      u_if.OUT_READY = 1'b0;
      chk("bp_valid_drop",   64'(u_if.OUT_VALID), 64'(0));
      chk("bp_overrun_stky", 64'(overrun),        64'(1));
      u_if.OUT_READY = 1'b1;
      do_tick(32'h0100_0000, 32'h0000_0000, 1'b1, 24'h000000, 24'h002800);
      chk("overrun_stays", 64'(overrun), 64'(1));

      // CAL_START clears OVERRUN; reset mid-calibration restores reset values.
      cal_pulse();
      chk("cal_clr_overrun", 64'(overrun), 64'(0));
      do_tick(32'h0000_0500, 32'h0000_0600, 1'b0, '0, '0);
      do_tick(32'h0000_0500, 32'h0000_0600, 1'b0, '0, '0);
      chk("midcal_busy", 64'(cal_busy), 64'(1));
      RESETN = 1'b0;
      #1;
      chk_reset_vals("midcal_rst");
      step();
      RESETN = 1'b1;
      step();

      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
